// File: rtl/dmem_lsu_ctrl_pkg.sv
// Shared types and helpers for the data-memory load/store front-end.
// Size codes, FSM states, alignment check and store lane steering.
package dmem_lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    LSU_B   = 2'b00,
    LSU_H   = 2'b01,
    LSU_W   = 2'b10,
    LSU_ILL = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LD_DATA = 2'b01,
    ST_LD_HOLD = 2'b10,
    ST_ACK     = 2'b11
  } lsu_state_e;

  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      LSU_B:   bad = 1'b0;
      LSU_H:   bad = off[0];
      LSU_W:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lsu_byte_en(input lsu_size_e size, input logic [1:0] off);
    logic [3:0] be;
    be = '0;
    case (size)
      LSU_B:   be = 4'b0001 << off;
      LSU_H:   be = 4'b0011 << off;
      LSU_W:   be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Replicate the LSB-aligned store data so every enabled lane sees its bytes.
  function automatic logic [31:0] lsu_store_data(input lsu_size_e size, input logic [31:0] d);
    logic [31:0] wd;
    wd = '0;
    case (size)
      LSU_B:   wd = {4{d[7:0]}};
      LSU_H:   wd = {2{d[15:0]}};
      LSU_W:   wd = d;
      default: wd = '0;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_load_align.sv
// Load formatter: extracts the addressed lane from a 32-bit SRAM word and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
  import dmem_lsu_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_lane;
  logic        w_sbit;

  assign w_lane = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_data = w_lane;
    w_sbit = 1'b0;
    case (i_size)
      LSU_B: begin
        w_sbit = w_lane[7] & ~i_unsigned;
        o_data = {{24{w_sbit}}, w_lane[7:0]};
      end
      LSU_H: begin
        w_sbit = w_lane[15] & ~i_unsigned;
        o_data = {{16{w_sbit}}, w_lane[15:0]};
      end
      default: o_data = w_lane;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store front-end for a byte-masked, 1-cycle-read data SRAM.
// One op in flight; responses are held stable until consumed.
module dmem_lsu_ctrl
  import dmem_lsu_ctrl_pkg::*;
#(
  parameter int ADDR_WHITH = 10,
  parameter int DATA_WHITH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WHITH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WHITH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  sram_cs,
  output logic [3:0]            sram_we,
  output logic [ADDR_WHITH-1:0] sram_addr,
  output logic [DATA_WHITH-1:0] sram_wdata,
  input  logic [DATA_WHITH-1:0] sram_rdata
);

  if (DATA_WHITH != 32) begin : g_bad_width
    $error("dmem_lsu_ctrl: only DATA_WHITH = 32 is supported");
  end

  lsu_state_e  r_state, w_state_nxt;
  logic [1:0]  r_off;
  lsu_size_e   r_size;
  logic        r_uns;
  logic        r_err;
  logic [31:0] r_hold;

  lsu_size_e   w_size;
  logic        w_accept;
  logic        w_err;
  logic        w_sram_go;
  logic [31:0] w_fmt;
  logic        w_unused_addr;

  assign w_unused_addr = ^req_addr[31:ADDR_WHITH+2];

  assign resp_valid = (r_state != ST_IDLE);
  assign req_ready  = !resp_valid || resp_ready;
  assign w_accept   = req_valid && req_ready;
  assign w_size     = lsu_size_e'(req_size);
  assign w_err      = lsu_misaligned(w_size, req_addr[1:0]);
  assign w_sram_go  = w_accept && !w_err;

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_sram_go) begin
      sram_cs   = 1'b1;
      sram_addr = req_addr[ADDR_WHITH+1:2];
      if (req_we) begin
        sram_we    = lsu_byte_en(w_size, req_addr[1:0]);
        sram_wdata = lsu_store_data(w_size, req_wdata);
      end
    end
  end

  lsu_load_align u_load_align (
    .i_rdata    (sram_rdata),
    .i_offset   (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_fmt)
  );

  // A new accept always wins: it can only happen when idle or when the
  // current response is being consumed in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = (w_err || req_we) ? ST_ACK : ST_LD_DATA;
    end else if (resp_valid && resp_ready) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_LD_DATA) begin
      w_state_nxt = ST_LD_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_off   <= '0;
      r_size  <= LSU_B;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_off  <= req_addr[1:0];
        r_size <= w_size;
        r_uns  <= req_unsigned;
        r_err  <= w_err;
      end
      // The SRAM zeroes rdata once cs drops, so a stalled load must be captured.
      if (r_state == ST_LD_DATA && !resp_ready) begin
        r_hold <= w_fmt;
      end
    end
  end

  always_comb begin
    resp_rdata = '0;
    case (r_state)
      ST_LD_DATA: resp_rdata = w_fmt;
      ST_LD_HOLD: resp_rdata = r_hold;
      default:    resp_rdata = '0;
    endcase
  end

  assign resp_err = (r_state == ST_ACK) && r_err;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a behavioural byte-masked SRAM that
// zeroes its read data whenever it is not being read.
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        sram_cs;
  logic [3:0]  sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023] = '{default: '0};

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.ADDR_WHITH(10), .DATA_WHITH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .sram_cs      (sram_cs),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always @(posedge clk) begin
    if (sram_cs) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
    if (sram_cs && sram_we == 4'b0000) sram_rdata <= mem[sram_addr];
    else                               sram_rdata <= '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // Single op with resp_ready=1: check SRAM drive in T, response in T+1, idle after.
  task automatic op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic exp_cs, input logic [3:0] exp_we, input logic [9:0] exp_saddr,
                    input logic [31:0] exp_swdata, input logic [31:0] exp_rdata, input logic exp_err);
    drive(we, size, uns, addr, wdata);
    #1;
    chk({tag, " cs"},    {31'd0, sram_cs},    {31'd0, exp_cs});
    chk({tag, " we"},    {28'd0, sram_we},    {28'd0, exp_we});
    chk({tag, " addr"},  {22'd0, sram_addr},  {22'd0, exp_saddr});
    chk({tag, " wdata"}, sram_wdata,          exp_swdata);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " rvalid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, " rdata"},  resp_rdata,          exp_rdata);
    chk({tag, " rerr"},   {31'd0, resp_err},   {31'd0, exp_err});
    @(negedge clk);
    chk({tag, " idle"},   {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst rdata",  resp_rdata,          32'd0);
    chk("rst rerr",   {31'd0, resp_err},   32'd0);
    chk("rst cs",     {31'd0, sram_cs},    32'd0);
    chk("rst ready",  {31'd0, req_ready},  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    op("SW10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 4'b1111, 10'd4, 32'hDEADBEEF, 32'h0, 0);
    op("LW10",  0, 2'b10, 0, 32'h10, 32'h0,        1, 4'b0000, 10'd4, 32'h0, 32'hDEADBEEF, 0);
    op("LB13",  0, 2'b00, 0, 32'h13, 32'h0,        1, 4'b0000, 10'd4, 32'h0, 32'hFFFFFFDE, 0);
    op("LBU13", 0, 2'b00, 1, 32'h13, 32'h0,        1, 4'b0000, 10'd4, 32'h0, 32'h000000DE, 0);
    op("LH12",  0, 2'b01, 0, 32'h12, 32'h0,        1, 4'b0000, 10'd4, 32'h0, 32'hFFFFDEAD, 0);
    op("LHU10", 0, 2'b01, 1, 32'h10, 32'h0,        1, 4'b0000, 10'd4, 32'h0, 32'h0000BEEF, 0);
    op("LWwrap",0, 2'b10, 0, 32'h1010, 32'h0,      1, 4'b0000, 10'd4, 32'h0, 32'hDEADBEEF, 0);
    op("SB21",  1, 2'b00, 0, 32'h21, 32'h000000A5, 1, 4'b0010, 10'd8, 32'hA5A5A5A5, 32'h0, 0);
    op("SH22",  1, 2'b01, 0, 32'h22, 32'h00001234, 1, 4'b1100, 10'd8, 32'h12341234, 32'h0, 0);
    op("LW20",  0, 2'b10, 0, 32'h20, 32'h0,        1, 4'b0000, 10'd8, 32'h0, 32'h1234A500, 0);
    op("LB21",  0, 2'b00, 0, 32'h21, 32'h0,        1, 4'b0000, 10'd8, 32'h0, 32'hFFFFFFA5, 0);

    // Stalled load: a second request waits on req_ready while the first is held.
    resp_ready = 1'b0;
    drive(0, 2'b10, 0, 32'h10, 32'h0);
    #1;
    chk("stall T cs", {31'd0, sram_cs}, 32'd1);
    @(negedge clk);
    drive(0, 2'b10, 0, 32'h20, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall rvalid", {31'd0, resp_valid}, 32'd1);
      chk("stall rdata",  resp_rdata,          32'hDEADBEEF);
      chk("stall ready",  {31'd0, req_ready},  32'd0);
      chk("stall cs",     {31'd0, sram_cs},    32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    chk("release ready", {31'd0, req_ready}, 32'd1);
    chk("release cs",    {31'd0, sram_cs},   32'd1);
    chk("release addr",  {22'd0, sram_addr}, 32'd8);
    @(negedge clk);
    req_valid = 1'b0;
    chk("2nd rdata", resp_rdata, 32'h1234A500);
    @(negedge clk);
    chk("2nd idle", {31'd0, resp_valid}, 32'd0);

    op("ERR_LW11", 0, 2'b10, 0, 32'h11, 32'h0, 0, 4'b0000, 10'd0, 32'h0, 32'h0, 1);
    op("ERR_LH03", 0, 2'b01, 0, 32'h03, 32'h0, 0, 4'b0000, 10'd0, 32'h0, 32'h0, 1);
    op("ERR_ILL",  0, 2'b11, 0, 32'h00, 32'h0, 0, 4'b0000, 10'd0, 32'h0, 32'h0, 1);
    op("ERR_SW",   1, 2'b10, 0, 32'h12, 32'h55, 0, 4'b0000, 10'd0, 32'h0, 32'h0, 1);

    // Back-to-back SW / LW / LW, one accept per cycle.
    drive(1, 2'b10, 0, 32'h30, 32'hCAFEF00D);
    #1;
    chk("b2b SW we", {28'd0, sram_we}, 32'hF);
    @(negedge clk);
    chk("b2b SW ack", {31'd0, resp_valid}, 32'd1);
    chk("b2b SW rdata", resp_rdata, 32'h0);
    drive(0, 2'b10, 0, 32'h30, 32'h0);
    #1;
    chk("b2b LW1 cs",   {31'd0, sram_cs},   32'd1);
    chk("b2b LW1 addr", {22'd0, sram_addr}, 32'd12);
    @(negedge clk);
    chk("b2b LW1 rdata", resp_rdata, 32'hCAFEF00D);
    drive(0, 2'b10, 0, 32'h10, 32'h0);
    #1;
    chk("b2b LW2 cs", {31'd0, sram_cs}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b LW2 rdata", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b idle", {31'd0, resp_valid}, 32'd0);

    // Asynchronous reset while a load response is held.
    resp_ready = 1'b0;
    drive(0, 2'b10, 0, 32'h10, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold pre-rst", resp_rdata, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst rvalid mid", {31'd0, resp_valid}, 32'd0);
    chk("rst rdata mid",  resp_rdata,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post-rst idle", {31'd0, resp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
